// File: rtl/lmapa_ctrl_if.sv
// lmapa_ctrl_if: command/sensor/status bundle between the wall-follower
// controller and its environment (host start pulse plus the maze map block).
interface lmapa_ctrl_if;
  logic        start;       // one-cycle run request from the host
  logic        head;        // map sensor: wall ahead
  logic        left;        // map sensor: wall to the left
  logic [2:0]  acao;        // single-cycle move command to the map
  logic [2:0]  orientacao;  // facing used by the map for sensing
  logic        busy;
  logic        done;
  logic        stuck;
  logic [7:0]  linha;
  logic [7:0]  coluna;
  logic [15:0] passos;

  // The controller side
  modport master (
    input  start, head, left,
    output acao, orientacao, busy, done, stuck, linha, coluna, passos
  );

  // The host/map side
  modport slave (
    output start, head, left,
    input  acao, orientacao, busy, done, stuck, linha, coluna, passos
  );
endinterface

// File: rtl/lmapa_ctrl.sv
// lmapa_ctrl: left-hand wall-follower that drives the maze map block.
// Waits SETTLE cycles after every command/orientation change, samples the
// head/left sensors (ORed with grid-edge walls), and either turns left and
// moves, moves forward, or turns right. Four right turns in a row = trapped.
// Build option: define LMAPA_CTRL_TIMEOUT_EN to end a run as STUCK once
// MAX_PASSOS moves have been made (the goal check keeps priority).
module lmapa_ctrl #(
  parameter int ROWS       = 10,
  parameter int COLS       = 20,
  parameter int START_ROW  = 9,
  parameter int START_COL  = 16,
  parameter int GOAL_ROW   = 0,
  parameter int GOAL_COL   = 0,
  parameter int SETTLE     = 2,
  parameter int MAX_PASSOS = 1000
) (
  input  logic         clockc1,
  input  logic         reset,
  lmapa_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DECIDE, S_MOVE, S_DONE, S_STUCK
  } state_t;

  // Facing codes as seen by the map (note E/S differ from the move codes)
  localparam logic [2:0] ORI_N = 3'b001;
  localparam logic [2:0] ORI_W = 3'b010;
  localparam logic [2:0] ORI_E = 3'b011;
  localparam logic [2:0] ORI_S = 3'b100;

  localparam logic [2:0] ACAO_NONE = 3'b000;
  localparam logic [2:0] ACAO_N    = 3'b001;
  localparam logic [2:0] ACAO_W    = 3'b010;
  localparam logic [2:0] ACAO_S    = 3'b011;
  localparam logic [2:0] ACAO_E    = 3'b100;

  localparam logic [7:0] START_ROW_L = 8'(START_ROW);
  localparam logic [7:0] START_COL_L = 8'(START_COL);
  localparam logic [7:0] GOAL_ROW_L  = 8'(GOAL_ROW);
  localparam logic [7:0] GOAL_COL_L  = 8'(GOAL_COL);
  localparam logic [7:0] LAST_ROW    = 8'(ROWS - 1);
  localparam logic [7:0] LAST_COL    = 8'(COLS - 1);
  localparam bit         START_AT_GOAL = (START_ROW == GOAL_ROW) && (START_COL == GOAL_COL);

  localparam int         CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

`ifdef LMAPA_CTRL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam logic [16:0] PASSOS_LIMIT = 17'(MAX_PASSOS);

  state_t        state_reg,  state_next;
  logic [2:0]    ori_reg,    ori_next;
  logic [7:0]    linha_reg,  linha_next;
  logic [7:0]    coluna_reg, coluna_next;
  logic [15:0]   passos_reg, passos_next;
  logic [2:0]    turns_reg,  turns_next;
  logic [CW-1:0] settle_reg, settle_next;

  logic       at_goal;
  logic       limit_hit;
  logic [2:0] left_dir;
  logic       left_blk;
  logic       head_blk;

  function automatic logic [2:0] rot_left(input logic [2:0] d);
    case (d)
      ORI_N:   return ORI_W;
      ORI_W:   return ORI_S;
      ORI_S:   return ORI_E;
      ORI_E:   return ORI_N;
      default: return ORI_N;
    endcase
  endfunction

  function automatic logic [2:0] rot_right(input logic [2:0] d);
    case (d)
      ORI_N:   return ORI_E;
      ORI_E:   return ORI_S;
      ORI_S:   return ORI_W;
      ORI_W:   return ORI_N;
      default: return ORI_N;
    endcase
  endfunction

  // True when stepping from (r,c) towards d would leave the grid
  function automatic logic edge_wall(input logic [2:0] d, input logic [7:0] r, input logic [7:0] c);
    case (d)
      ORI_N:   return r == 8'd0;
      ORI_S:   return r == LAST_ROW;
      ORI_W:   return c == 8'd0;
      ORI_E:   return c == LAST_COL;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] move_code(input logic [2:0] d);
    case (d)
      ORI_N:   return ACAO_N;
      ORI_W:   return ACAO_W;
      ORI_S:   return ACAO_S;
      ORI_E:   return ACAO_E;
      default: return ACAO_NONE;
    endcase
  endfunction

  // Decision inputs: sensors are only meaningful in DECIDE
  assign at_goal   = (linha_reg == GOAL_ROW_L) && (coluna_reg == GOAL_COL_L);
  assign limit_hit = TIMEOUT_EN && ({1'b0, passos_reg} >= PASSOS_LIMIT);
  assign left_dir  = rot_left(ori_reg);
  assign left_blk  = bus.left | edge_wall(left_dir, linha_reg, coluna_reg);
  assign head_blk  = bus.head | edge_wall(ori_reg, linha_reg, coluna_reg);

  // State and datapath registers; reset mid-run drops straight back to IDLE
  always_ff @(posedge clockc1 or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      ori_reg    <= ORI_N;
      linha_reg  <= START_ROW_L;
      coluna_reg <= START_COL_L;
      passos_reg <= '0;
      turns_reg  <= '0;
      settle_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ori_reg    <= ori_next;
      linha_reg  <= linha_next;
      coluna_reg <= coluna_next;
      passos_reg <= passos_next;
      turns_reg  <= turns_next;
      settle_reg <= settle_next;
    end
  end

  // Next-state and datapath updates for the wall-following sequence
  always_comb begin
    state_next  = state_reg;
    ori_next    = ori_reg;
    linha_next  = linha_reg;
    coluna_next = coluna_reg;
    passos_next = passos_reg;
    turns_next  = turns_reg;
    settle_next = '0;

    case (state_reg)
      S_IDLE, S_DONE, S_STUCK: begin
        if (bus.start) begin
          ori_next    = ORI_N;
          linha_next  = START_ROW_L;
          coluna_next = START_COL_L;
          passos_next = '0;
          turns_next  = '0;
          state_next  = START_AT_GOAL ? S_DONE : S_WAIT;
        end
      end

      S_WAIT: begin
        if (settle_reg == SETTLE_LAST) begin
          state_next = S_DECIDE;
        end else begin
          settle_next = settle_reg + CW'(1);
        end
      end

      S_DECIDE: begin
        if (at_goal) begin
          state_next = S_DONE;
        end else if (limit_hit) begin
          state_next = S_STUCK;
        end else if (!left_blk) begin
          // Turn and move in one go; the map sees the new facing with acao
          ori_next   = left_dir;
          state_next = S_MOVE;
        end else if (!head_blk) begin
          state_next = S_MOVE;
        end else begin
          ori_next   = rot_right(ori_reg);
          turns_next = turns_reg + 3'd1;
          state_next = (turns_reg == 3'd3) ? S_STUCK : S_WAIT;
        end
      end

      S_MOVE: begin
        case (ori_reg)
          ORI_N:   linha_next  = linha_reg - 8'd1;
          ORI_S:   linha_next  = linha_reg + 8'd1;
          ORI_W:   coluna_next = coluna_reg - 8'd1;
          ORI_E:   coluna_next = coluna_reg + 8'd1;
          default: ;
        endcase
        if (passos_reg != 16'hFFFF) begin
          passos_next = passos_reg + 16'd1;
        end
        turns_next = '0;
        state_next = S_WAIT;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decode straight from registers, so reset clears acao at once
  assign bus.acao       = (state_reg == S_MOVE) ? move_code(ori_reg) : ACAO_NONE;
  assign bus.orientacao = ori_reg;
  assign bus.busy       = (state_reg == S_WAIT) || (state_reg == S_DECIDE) || (state_reg == S_MOVE);
  assign bus.done       = (state_reg == S_DONE);
  assign bus.stuck      = (state_reg == S_STUCK);
  assign bus.linha      = linha_reg;
  assign bus.coluna     = coluna_reg;
  assign bus.passos     = passos_reg;

  // Edge masking must keep every move inside the grid (no 8-bit wrap)
  a_no_wrap: assert property (@(posedge clockc1) disable iff (!reset)
    (state_reg == S_MOVE) |-> !edge_wall(ori_reg, linha_reg, coluna_reg));

endmodule

// File: tb/tb_lmapa_ctrl.sv
// tb_lmapa_ctrl: directed scenarios plus a randomized run of the wall
// follower compared against a grid-level reference model of the robot.
module tb_lmapa_ctrl;
  localparam int SETTLE = 2;
  localparam int M_ROWS = 10;
  localparam int M_COLS = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic start_s, head_s, left_s;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  lmapa_ctrl_if bus_a ();
  lmapa_ctrl_if bus_b ();
  lmapa_ctrl_if bus_c ();

  assign bus_a.start = start_s;
  assign bus_a.head  = head_s;
  assign bus_a.left  = left_s;
  assign bus_b.start = start_s;
  assign bus_b.head  = head_s;
  assign bus_b.left  = left_s;
  assign bus_c.start = start_s;
  assign bus_c.head  = head_s;
  assign bus_c.left  = left_s;

  // Start (9,16), goal (0,16)
  lmapa_ctrl #(.GOAL_ROW(0), .GOAL_COL(16)) u_a (.clockc1(clk), .reset(rst_n), .bus(bus_a));
  // Corridor: goal (5,16)
  lmapa_ctrl #(.GOAL_ROW(5), .GOAL_COL(16)) u_b (.clockc1(clk), .reset(rst_n), .bus(bus_b));
  // Corner start (0,0)
  lmapa_ctrl #(.START_ROW(0), .START_COL(0), .GOAL_ROW(9), .GOAL_COL(19))
    u_c (.clockc1(clk), .reset(rst_n), .bus(bus_c));

`ifdef LMAPA_CTRL_TIMEOUT_EN
  lmapa_ctrl_if bus_t ();
  assign bus_t.start = start_s;
  assign bus_t.head  = head_s;
  assign bus_t.left  = left_s;
  lmapa_ctrl #(.GOAL_ROW(5), .GOAL_COL(5), .MAX_PASSOS(3)) u_t (.clockc1(clk), .reset(rst_n), .bus(bus_t));
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start_s = 1'b0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Model heading: 0=N 1=W 2=S 3=E (counter-clockwise order)
  function automatic int step_dr(input int h);
    return (h == 0) ? -1 : ((h == 2) ? 1 : 0);
  endfunction

  function automatic int step_dc(input int h);
    return (h == 1) ? -1 : ((h == 3) ? 1 : 0);
  endfunction

  function automatic bit cell_free(input int r, input int c, input int h);
    int nr;
    int nc;
    nr = r + step_dr(h);
    nc = c + step_dc(h);
    return (nr >= 0) && (nr < M_ROWS) && (nc >= 0) && (nc < M_COLS);
  endfunction

  function automatic logic [2:0] ori_code(input int h);
    case (h)
      0:       return 3'b001;
      1:       return 3'b010;
      2:       return 3'b100;
      default: return 3'b011;
    endcase
  endfunction

  function automatic logic [2:0] acao_code(input int h);
    case (h)
      0:       return 3'b001;
      1:       return 3'b010;
      2:       return 3'b011;
      default: return 3'b100;
    endcase
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    start_s = 1'b0;
    head_s  = 1'b0;
    left_s  = 1'b0;
    tick();
    tick();
    n_checks++; if (bus_a.acao !== 3'b000) $display("FAIL reset_acao: got %b want 000", bus_a.acao); else n_pass++;
    n_checks++; if (bus_a.orientacao !== 3'b001) $display("FAIL reset_ori: got %b want 001", bus_a.orientacao); else n_pass++;
    n_checks++; if ({bus_a.busy, bus_a.done, bus_a.stuck} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {bus_a.busy, bus_a.done, bus_a.stuck}); else n_pass++;
    n_checks++; if (bus_a.linha !== 8'd9 || bus_a.coluna !== 8'd16) $display("FAIL reset_pos_a: got (%0d,%0d) want (9,16)", bus_a.linha, bus_a.coluna); else n_pass++;
    n_checks++; if (bus_a.passos !== 16'd0) $display("FAIL reset_passos: got %0d want 0", bus_a.passos); else n_pass++;
    n_checks++; if (bus_c.linha !== 8'd0 || bus_c.coluna !== 8'd0) $display("FAIL reset_pos_c: got (%0d,%0d) want (0,0)", bus_c.linha, bus_c.coluna); else n_pass++;
    rst_n = 1'b1;
    tick();
    $display("reset: outputs at reset values checked");
  endtask

  task automatic test_open_grid();
    int cyc;
    do_reset();
    head_s = 1'b0;
    left_s = 1'b0;
    start_s = 1'b1; tick(); start_s = 1'b0;
    repeat (SETTLE + 1) tick();
    n_checks++; if (bus_a.acao !== 3'b010) $display("FAIL open_first_acao: got %b want 010", bus_a.acao); else n_pass++;
    n_checks++; if (bus_a.orientacao !== 3'b010) $display("FAIL open_first_ori: got %b want 010", bus_a.orientacao); else n_pass++;
    tick();
    n_checks++; if (bus_a.coluna !== 8'd15 || bus_a.linha !== 8'd9) $display("FAIL open_first_pos: got (%0d,%0d) want (9,15)", bus_a.linha, bus_a.coluna); else n_pass++;
    n_checks++; if (bus_a.passos !== 16'd1 || bus_a.acao !== 3'b000) $display("FAIL open_first_passos: got passos=%0d acao=%b want 1/000", bus_a.passos, bus_a.acao); else n_pass++;
    cyc = 0;
    while (bus_a.done !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
    // Bottom row west, column 0 north, top row east: 16 + 9 + 16 moves
    n_checks++; if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0) $display("FAIL open_done: got done=%b busy=%b want 1/0", bus_a.done, bus_a.busy); else n_pass++;
    n_checks++; if (bus_a.passos !== 16'd41) $display("FAIL open_passos: got %0d want 41", bus_a.passos); else n_pass++;
    n_checks++; if (bus_a.linha !== 8'd0 || bus_a.coluna !== 8'd16) $display("FAIL open_goal_pos: got (%0d,%0d) want (0,16)", bus_a.linha, bus_a.coluna); else n_pass++;
    $display("open_grid: goal reached after %0d cycles, passos=%0d", cyc, bus_a.passos);
  endtask

  task automatic test_trap();
    logic [2:0] seen[$];
    logic [2:0] prev;
    int cyc;
    bit acao_hit;
    do_reset();
    head_s = 1'b1;
    left_s = 1'b1;
    start_s = 1'b1; tick(); start_s = 1'b0;
    prev = bus_a.orientacao;
    acao_hit = 1'b0;
    cyc = 0;
    while (bus_a.stuck !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
      if (bus_a.acao !== 3'b000) acao_hit = 1'b1;
      if (bus_a.orientacao !== prev) begin
        seen.push_back(bus_a.orientacao);
        prev = bus_a.orientacao;
      end
    end
    n_checks++; if (seen.size() < 3) $display("FAIL trap_turns: got %0d turns want >=3", seen.size()); else n_pass++;
    if (seen.size() >= 3) begin
      n_checks++; if (seen[0] !== 3'b011) $display("FAIL trap_turn1: got %b want 011", seen[0]); else n_pass++;
      n_checks++; if (seen[1] !== 3'b100) $display("FAIL trap_turn2: got %b want 100", seen[1]); else n_pass++;
      n_checks++; if (seen[2] !== 3'b010) $display("FAIL trap_turn3: got %b want 010", seen[2]); else n_pass++;
    end
    n_checks++; if (bus_a.stuck !== 1'b1 || bus_a.busy !== 1'b0) $display("FAIL trap_stuck: got stuck=%b busy=%b want 1/0", bus_a.stuck, bus_a.busy); else n_pass++;
    n_checks++; if (bus_a.passos !== 16'd0 || acao_hit) $display("FAIL trap_nomove: got passos=%0d acao_seen=%0d want 0/0", bus_a.passos, acao_hit); else n_pass++;
    $display("trap: stuck after %0d cycles, %0d orientation changes", cyc, seen.size());
  endtask

  task automatic test_corridor();
    int cyc, npulse, last_t, bad_len, bad_gap, bad_val;
    logic [2:0] prev_acao;
    do_reset();
    head_s = 1'b0;
    left_s = 1'b1;
    start_s = 1'b1; tick(); start_s = 1'b0;
    cyc = 0; npulse = 0; last_t = 0; bad_len = 0; bad_gap = 0; bad_val = 0;
    prev_acao = 3'b000;
    while (bus_b.done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
      if (bus_b.acao !== 3'b000) begin
        if (prev_acao !== 3'b000) bad_len++;
        else begin
          if (bus_b.acao !== 3'b001) bad_val++;
          if (npulse > 0 && (cyc - last_t) != SETTLE + 2) bad_gap++;
          npulse++;
          last_t = cyc;
          $display("corridor: acao=%b at cycle %0d row=%0d", bus_b.acao, cyc, bus_b.linha);
        end
      end
      prev_acao = bus_b.acao;
    end
    n_checks++; if (npulse != 4) $display("FAIL corridor_pulses: got %0d want 4", npulse); else n_pass++;
    n_checks++; if (bad_len != 0 || bad_val != 0) $display("FAIL corridor_shape: got long=%0d wrongcode=%0d want 0/0", bad_len, bad_val); else n_pass++;
    n_checks++; if (bad_gap != 0) $display("FAIL corridor_spacing: got %0d bad gaps want 0", bad_gap); else n_pass++;
    n_checks++; if (bus_b.done !== 1'b1 || bus_b.linha !== 8'd5) $display("FAIL corridor_done: got done=%b row=%0d want 1/5", bus_b.done, bus_b.linha); else n_pass++;
    n_checks++; if (bus_b.passos !== 16'd4) $display("FAIL corridor_passos: got %0d want 4", bus_b.passos); else n_pass++;
  endtask

  task automatic test_corner();
    int cyc;
    bit row_bad;
    do_reset();
    head_s = 1'b0;
    left_s = 1'b0;
    start_s = 1'b1; tick(); start_s = 1'b0;
    cyc = 0;
    row_bad = 1'b0;
    while (bus_c.acao === 3'b000 && cyc < 100) begin
      tick();
      cyc++;
      if (bus_c.linha !== 8'd0) row_bad = 1'b1;
    end
    n_checks++; if (bus_c.acao !== 3'b100 || bus_c.orientacao !== 3'b011) $display("FAIL corner_move: got acao=%b ori=%b want 100/011", bus_c.acao, bus_c.orientacao); else n_pass++;
    tick();
    n_checks++; if (bus_c.coluna !== 8'd1 || bus_c.linha !== 8'd0) $display("FAIL corner_pos: got (%0d,%0d) want (0,1)", bus_c.linha, bus_c.coluna); else n_pass++;
    n_checks++; if (row_bad) $display("FAIL corner_row: got row change want row 0 throughout"); else n_pass++;
    $display("corner: first move east after %0d cycles", cyc);
  endtask

  task automatic test_reset_mid_move();
    int cyc;
    do_reset();
    head_s = 1'b0;
    left_s = 1'b0;
    start_s = 1'b1; tick(); start_s = 1'b0;
    cyc = 0;
    while (bus_a.acao === 3'b000 && cyc < 20) begin tick(); cyc++; end
    n_checks++; if (bus_a.acao !== 3'b010) $display("FAIL midreset_reach_move: got acao=%b want 010", bus_a.acao); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus_a.acao !== 3'b000) $display("FAIL midreset_acao: got %b want 000", bus_a.acao); else n_pass++;
    n_checks++; if (bus_a.orientacao !== 3'b001 || bus_a.busy !== 1'b0) $display("FAIL midreset_state: got ori=%b busy=%b want 001/0", bus_a.orientacao, bus_a.busy); else n_pass++;
    n_checks++; if (bus_a.linha !== 8'd9 || bus_a.coluna !== 8'd16 || bus_a.passos !== 16'd0) $display("FAIL midreset_pos: got (%0d,%0d) passos=%0d want (9,16) 0", bus_a.linha, bus_a.coluna, bus_a.passos); else n_pass++;
    tick();
    tick();
    n_checks++; if (bus_a.acao !== 3'b000 || bus_a.busy !== 1'b0) $display("FAIL midreset_hold: got acao=%b busy=%b want 000/0", bus_a.acao, bus_a.busy); else n_pass++;
    rst_n = 1'b1;
    tick();
    start_s = 1'b1; tick(); start_s = 1'b0;
    repeat (SETTLE + 1) tick();
    n_checks++; if (bus_a.acao !== 3'b010) $display("FAIL midreset_rerun_acao: got %b want 010", bus_a.acao); else n_pass++;
    tick();
    n_checks++; if (bus_a.coluna !== 8'd15 || bus_a.passos !== 16'd1) $display("FAIL midreset_rerun_pos: got col=%0d passos=%0d want 15/1", bus_a.coluna, bus_a.passos); else n_pass++;
    $display("reset_mid_move: abort and rerun checked");
  endtask

`ifdef LMAPA_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, npulse;
    do_reset();
    head_s = 1'b0;
    left_s = 1'b0;
    start_s = 1'b1; tick(); start_s = 1'b0;
    cyc = 0;
    npulse = 0;
    while (bus_t.stuck !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
      if (bus_t.acao !== 3'b000) npulse++;
    end
    repeat (10) begin tick(); if (bus_t.acao !== 3'b000) npulse++; end
    n_checks++; if (bus_t.stuck !== 1'b1) $display("FAIL timeout_stuck: got %b want 1", bus_t.stuck); else n_pass++;
    n_checks++; if (npulse != 3 || bus_t.passos !== 16'd3) $display("FAIL timeout_moves: got pulses=%0d passos=%0d want 3/3", npulse, bus_t.passos); else n_pass++;
    $display("timeout: stuck after %0d cycles", cyc);
  endtask
`endif

  // Robot-level model of u_a: mode 0 open sensors, 1 random sensors, 2 walls
  task automatic test_model_run(input int mode, input int max_dec);
    int r, c, h, hl, turns, steps;
    bit fin, mv;
    logic lh, ll;
    r = 9; c = 16; h = 0; turns = 0; steps = 0; fin = 1'b0;
    start_s = 1'b1; tick(); start_s = 1'b0;
    for (int d = 0; d < max_dec && !fin; d++) begin
      for (int i = 0; i < SETTLE; i++) begin
        if (mode == 1) begin
          head_s = 1'($urandom_range(0, 1));
          left_s = 1'($urandom_range(0, 1));
        end
        n_checks++; if (bus_a.acao !== 3'b000 || bus_a.busy !== 1'b1) $display("FAIL model_settle: got acao=%b busy=%b want 000/1", bus_a.acao, bus_a.busy); else n_pass++;
        tick();
      end
      lh = (mode == 2) ? 1'b1 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      ll = (mode == 2) ? 1'b1 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      head_s = lh;
      left_s = ll;
      if (r == 0 && c == 16) begin
        tick();
        n_checks++; if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.passos !== 16'(steps)) $display("FAIL model_goal: got done=%b busy=%b passos=%0d want 1/0/%0d", bus_a.done, bus_a.busy, bus_a.passos, steps); else n_pass++;
        $display("model: goal after %0d moves", steps);
        fin = 1'b1;
      end else begin
        hl = (h + 1) % 4;
        mv = 1'b1;
        if (!ll && cell_free(r, c, hl)) h = hl;
        else if (!(!lh && cell_free(r, c, h))) begin
          h = (h + 3) % 4;
          turns++;
          mv = 1'b0;
        end
        tick();
        if (mv) begin
          n_checks++; if (bus_a.acao !== acao_code(h) || bus_a.orientacao !== ori_code(h)) $display("FAIL model_move: got acao=%b ori=%b want %b/%b", bus_a.acao, bus_a.orientacao, acao_code(h), ori_code(h)); else n_pass++;
          r = r + step_dr(h);
          c = c + step_dc(h);
          steps++;
          turns = 0;
          tick();
          n_checks++; if (bus_a.linha !== 8'(r) || bus_a.coluna !== 8'(c) || bus_a.passos !== 16'(steps)) $display("FAIL model_pos: got (%0d,%0d) passos=%0d want (%0d,%0d) %0d", bus_a.linha, bus_a.coluna, bus_a.passos, r, c, steps); else n_pass++;
          $display("model: move %0d heading=%0d to (%0d,%0d)", steps, h, r, c);
        end else begin
          n_checks++; if (bus_a.orientacao !== ori_code(h) || bus_a.acao !== 3'b000) $display("FAIL model_turn: got ori=%b acao=%b want %b/000", bus_a.orientacao, bus_a.acao, ori_code(h)); else n_pass++;
          if (turns == 4) begin
            n_checks++; if (bus_a.stuck !== 1'b1 || bus_a.busy !== 1'b0) $display("FAIL model_trap: got stuck=%b busy=%b want 1/0", bus_a.stuck, bus_a.busy); else n_pass++;
            $display("model: trapped after %0d moves", steps);
            fin = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 6; run++) begin
      do_reset();
      test_model_run(1, 50);
    end
    do_reset();
    test_model_run(0, 200);
    do_reset();
    test_model_run(2, 10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_open_grid();
    test_trap();
    test_corridor();
    test_corner();
    test_reset_mid_move();
`ifdef LMAPA_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
